// File: rtl/colour_sector_detect_pkg.sv
// Shared types and default geometry for the colour sector detector.
// Imported by the pixel interface, the classifier and the top level.
package colour_detect_pkg;

    localparam int unsigned CH_W_DEF      = 4;
    localparam int unsigned IMG_W_DEF     = 320;
    localparam int unsigned IMG_H_DEF     = 240;
    localparam int unsigned N_SECTORS_DEF = 4;

    typedef enum logic [1:0] {
        TGT_RED   = 2'd0,
        TGT_GREEN = 2'd1,
        TGT_BLUE  = 2'd2,
        TGT_OFF   = 2'd3
    } target_e;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        COUNT    = 2'd1,
        LATCH    = 2'd2
    } state_e;

endpackage

// File: rtl/colour_sector_detect_if.sv
// RGB pixel stream tapped from the frame buffer read path.
// The source drives the master side; the detector listens on the slave side.
interface colour_sector_detect_if
    import colour_detect_pkg::*;
#(
    parameter int unsigned CH_W = CH_W_DEF
);
    logic [3*CH_W-1:0] data_in;
    logic              valid_in;
    logic              sop_in;

    modport master (output data_in, valid_in, sop_in);
    modport slave  (input  data_in, valid_in, sop_in);
endinterface

// File: rtl/colour_sector_detect_pixel_classifier.sv
// Splits a pixel into channels, tests it against the selected target colour
// and registers the match bit (pipeline stage 1).
module pixel_classifier
    import colour_detect_pkg::*;
#(
    parameter int unsigned CH_W = CH_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [3*CH_W-1:0] i_pixel,
    input  logic [1:0]        i_target_sel,
    input  logic [CH_W-1:0]   i_hi_thresh,
    input  logic [CH_W-1:0]   i_lo_thresh,
    output logic              o_match
);
    logic [CH_W-1:0] w_r, w_g, w_b;
    logic [CH_W-1:0] w_tgt, w_oth_a, w_oth_b;
    logic            w_en;
    logic            w_match;
    target_e         w_sel;
    logic            r_match;

    assign w_r   = i_pixel[3*CH_W-1:2*CH_W];
    assign w_g   = i_pixel[2*CH_W-1:CH_W];
    assign w_b   = i_pixel[CH_W-1:0];
    assign w_sel = target_e'(i_target_sel);

    always_comb begin
        w_tgt   = '0;
        w_oth_a = '0;
        w_oth_b = '0;
        w_en    = 1'b1;
        case (w_sel)
            TGT_RED:   begin w_tgt = w_r; w_oth_a = w_g; w_oth_b = w_b; end
            TGT_GREEN: begin w_tgt = w_g; w_oth_a = w_r; w_oth_b = w_b; end
            TGT_BLUE:  begin w_tgt = w_b; w_oth_a = w_r; w_oth_b = w_g; end
            default:   w_en = 1'b0;
        endcase
    end

    assign w_match = w_en & (w_tgt >= i_hi_thresh)
                   & (w_oth_a <= i_lo_thresh) & (w_oth_b <= i_lo_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= i_valid & w_match;
        end
    end

    assign o_match = r_match;
endmodule

// File: rtl/colour_sector_detect.sv
// Counts target-colour pixels per frame across vertical sectors, latches the
// per-frame totals, picks the dominant sector and drives a hysteretic flag.
module colour_sector_detect
    import colour_detect_pkg::*;
#(
    parameter int unsigned CH_W      = CH_W_DEF,
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned IMG_H     = IMG_H_DEF,
    parameter int unsigned N_SECTORS = N_SECTORS_DEF,
    parameter int unsigned CNT_W     = $clog2(IMG_W*IMG_H+1),
    parameter int unsigned SEC_W     = $clog2(N_SECTORS)
) (
    input  logic                       clk,
    input  logic                       reset,
    colour_sector_detect_if.slave      pix,
    input  logic [1:0]                 target_sel,
    input  logic [CH_W-1:0]            hi_thresh,
    input  logic [CH_W-1:0]            lo_thresh,
    input  logic [CNT_W-1:0]           count_on,
    input  logic [CNT_W-1:0]           count_off,
    output logic [CNT_W-1:0]           total_count,
    output logic [N_SECTORS*CNT_W-1:0] sector_counts,
    output logic [SEC_W-1:0]           dominant_sector,
    output logic                       flag_reached,
    output logic                       frame_done,
    output logic                       frame_error
);
    localparam int unsigned SUB_N  = IMG_W / N_SECTORS;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned LINE_W = $clog2(IMG_H);
    localparam int unsigned SUB_W  = $clog2(SUB_N);

    state_e            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col,  w_col_cur,  w_col_nxt;
    logic [LINE_W-1:0] r_line, w_line_cur, w_line_nxt;
    logic [SUB_W-1:0]  r_sub,  w_sub_cur,  w_sub_nxt;
    logic [SEC_W-1:0]  r_sec,  w_sec_cur,  w_sec_nxt;
    logic              w_start, w_adv, w_take, w_abort, w_last_pix;

    logic              r_s1_vld, r_s1_first, r_s1_abort;
    logic [SEC_W-1:0]  r_s1_sec;
    logic              w_s1_match;

    logic [CNT_W-1:0]  r_acc     [N_SECTORS];
    logic [CNT_W-1:0]  w_inc     [N_SECTORS];
    logic [CNT_W-1:0]  w_fin     [N_SECTORS];
    logic [CNT_W-1:0]  r_sec_out [N_SECTORS];
    logic [CNT_W-1:0]  r_tot, w_tot_inc, w_tot_fin, r_tot_out;
    logic [CNT_W-1:0]  w_best_val;
    logic [SEC_W-1:0]  w_best_idx, r_dom;
    logic              r_flag, r_done, r_err;

    // A sop pixel is always pixel 0 of a new frame, whatever state we are in.
    assign w_start    = pix.valid_in & pix.sop_in;
    assign w_adv      = pix.valid_in & ~pix.sop_in & (r_state == COUNT);
    assign w_take     = w_start | w_adv;
    assign w_abort    = w_start & (r_state == COUNT);
    assign w_last_pix = w_adv & (r_col == COL_W'(IMG_W-1)) & (r_line == LINE_W'(IMG_H-1));

    assign w_col_cur  = w_start ? '0 : r_col;
    assign w_line_cur = w_start ? '0 : r_line;
    assign w_sub_cur  = w_start ? '0 : r_sub;
    assign w_sec_cur  = w_start ? '0 : r_sec;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_SOP: if (w_start) w_state_nxt = COUNT;
            COUNT:    if (w_last_pix) w_state_nxt = LATCH;
            LATCH:    w_state_nxt = w_start ? COUNT : WAIT_SOP;
            default:  w_state_nxt = WAIT_SOP;
        endcase
    end

    always_comb begin
        w_col_nxt  = w_col_cur + COL_W'(1);
        w_line_nxt = w_line_cur;
        w_sub_nxt  = w_sub_cur + SUB_W'(1);
        w_sec_nxt  = w_sec_cur;
        if (w_col_cur == COL_W'(IMG_W-1)) begin
            w_col_nxt  = '0;
            w_sub_nxt  = '0;
            w_sec_nxt  = '0;
            w_line_nxt = (w_line_cur == LINE_W'(IMG_H-1)) ? '0 : w_line_cur + LINE_W'(1);
        end else if (w_sub_cur == SUB_W'(SUB_N-1)) begin
            w_sub_nxt = '0;
            w_sec_nxt = w_sec_cur + SEC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT_SOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col      <= '0;
            r_line     <= '0;
            r_sub      <= '0;
            r_sec      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_abort <= 1'b0;
            r_s1_sec   <= '0;
        end else begin
            if (w_take) begin
                r_col  <= w_col_nxt;
                r_line <= w_line_nxt;
                r_sub  <= w_sub_nxt;
                r_sec  <= w_sec_nxt;
            end
            r_s1_vld   <= w_take;
            r_s1_first <= w_start;
            r_s1_abort <= w_abort;
            r_s1_sec   <= w_sec_cur;
        end
    end

    pixel_classifier #(.CH_W(CH_W)) u_classifier (
        .clk          (clk),
        .rst_n        (reset),
        .i_valid      (w_take),
        .i_pixel      (pix.data_in),
        .i_target_sel (target_sel),
        .i_hi_thresh  (hi_thresh),
        .i_lo_thresh  (lo_thresh),
        .o_match      (w_s1_match)
    );

    // Final counts include the pixel still sitting in stage 1, so LATCH can
    // publish the frame without waiting for one more accumulate cycle.
    always_comb begin
        for (int unsigned s = 0; s < N_SECTORS; s++) begin
            w_inc[s] = CNT_W'(w_s1_match && (r_s1_sec == SEC_W'(s)));
            w_fin[s] = r_acc[s] + w_inc[s];
        end
    end

    assign w_tot_inc = CNT_W'(w_s1_match);
    assign w_tot_fin = r_tot + w_tot_inc;

    always_comb begin
        w_best_val = w_fin[0];
        w_best_idx = '0;
        for (int unsigned s = 1; s < N_SECTORS; s++) begin
            if (w_fin[s] > w_best_val) begin
                w_best_val = w_fin[s];
                w_best_idx = SEC_W'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < N_SECTORS; s++) begin
                r_acc[s]     <= '0;
                r_sec_out[s] <= '0;
            end
            r_tot     <= '0;
            r_tot_out <= '0;
            r_dom     <= '0;
            r_flag    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == LATCH) begin
                for (int unsigned s = 0; s < N_SECTORS; s++) begin
                    r_sec_out[s] <= w_fin[s];
                    r_acc[s]     <= '0;
                end
                r_tot_out <= w_tot_fin;
                r_tot     <= '0;
                r_dom     <= w_best_idx;
                r_done    <= 1'b1;
                if (w_tot_fin >= count_on) begin
                    r_flag <= 1'b1;
                end else if (w_tot_fin < count_off) begin
                    r_flag <= 1'b0;
                end
            end else if (r_s1_vld) begin
                for (int unsigned s = 0; s < N_SECTORS; s++) begin
                    r_acc[s] <= r_s1_first ? w_inc[s] : w_fin[s];
                end
                r_tot <= r_s1_first ? w_tot_inc : w_tot_fin;
                r_err <= r_s1_first & r_s1_abort;
            end
        end
    end

    for (genvar s = 0; s < N_SECTORS; s++) begin : g_pack
        assign sector_counts[s*CNT_W +: CNT_W] = r_sec_out[s];
    end

    assign total_count     = r_tot_out;
    assign dominant_sector = r_dom;
    assign flag_reached    = r_flag;
    assign frame_done      = r_done;
    assign frame_error     = r_err;
endmodule
